// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared branch-type codes and predictor counter constants
package branch_predictor_pkg;
    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BLTU     = 3'd4,
        BGE      = 3'd5,
        BGEU     = 3'd6
    } br_type_e;
    localparam logic [1:0] CNT_RESET = 2'b01;
    localparam logic [1:0] CNT_ALLOC = 2'b10;
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: 2-bit saturating taken/not-taken counter with allocate load
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       ld,
    output logic [1:0] state
);
    always_ff @(posedge clk)
        if (rst)
            state <= CNT_RESET;
        else if (ld)
            state <= CNT_ALLOC;
        else if (inc && state != 2'b11)
            state <= state + 2'b01;
        else if (dec && state != 2'b00)
            state <= state - 2'b01;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, EX-stage resolve and stats
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic [31:0] PCE,
    input  logic [2:0]  BranchTypeE,
    input  logic        BranchE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    input  logic        StallE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE,
    output logic [31:0] BranchCnt,
    output logic [31:0] MissCnt
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;
    logic [ENTRIES-1:0] valid;
    logic [TW-1:0]      tags    [ENTRIES];
    logic [31:0]        targets [ENTRIES];
    logic [1:0]         ctr     [ENTRIES];
    logic [IW-1:0]      fidx, eidx;
    logic               hit_f, hit_e, is_br, active, upd, unused;
    assign fidx   = PCF[IW+1:2];
    assign eidx   = PCE[IW+1:2];
    assign hit_f  = valid[fidx] && tags[fidx] == PCF[31:IW+2];
    assign hit_e  = valid[eidx] && tags[eidx] == PCE[31:IW+2];
    assign unused = ^{PCF[1:0], PCE[1:0]};
    assign PredTakenF  = hit_f && ctr[fidx][1];
    assign PredTargetF = PredTakenF ? targets[fidx] : PCF + 32'd4;
    assign is_br  = BranchTypeE != NOBRANCH;
    assign active = !StallE && !CPU_RST;
    assign upd    = is_br && active;
    assign MispredictE = active && (is_br ? (BranchE != PredTakenE || (BranchE && PredTargetE != BrTargetE)) : PredTakenE);
    assign CorrectPCE  = (is_br && BranchE) ? BrTargetE : PCE + 32'd4;
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        sat_counter2 u_ctr (
            .clk   (CPU_CLK),
            .rst   (CPU_RST),
            .inc   (upd && hit_e && BranchE && eidx == IW'(g)),
            .dec   (upd && hit_e && !BranchE && eidx == IW'(g)),
            .ld    (upd && !hit_e && BranchE && eidx == IW'(g)),
            .state (ctr[g])
        );
    end
    always_ff @(posedge CPU_CLK)
        if (CPU_RST)
            valid <= '0;
        else if (upd && BranchE)
            valid[eidx] <= 1'b1;
    // a taken hit rewrites the same tag, so allocation and retarget share one write
    always_ff @(posedge CPU_CLK)
        if (upd && BranchE) begin
            tags[eidx]    <= PCE[31:IW+2];
            targets[eidx] <= BrTargetE;
        end
    always_ff @(posedge CPU_CLK) begin
        BranchCnt <= CPU_RST ? '0 : BranchCnt + {31'b0, upd};
        MissCnt   <= CPU_RST ? '0 : MissCnt + {31'b0, MispredictE};
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL be parameterised: ENTRIES, 16, number of direct-mapped table entries (power of two, 4..64).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- CPU_CLK  in  1  clock; all state updates on the rising edge.
- CPU_RST  in  1  synchronous, active-high reset.
- PCF  in  32  fetch-stage PC.
- PredTakenF  out  1  fetch-stage predict-taken.
- PredTargetF  out  32  predicted next PC.
- PCE  in  32  EX-stage PC of the instruction.
- BranchTypeE  in  3  EX branch type; NOBRANCH code = non-branch or bubble.
- BranchE  in  1  resolved outcome from the EX branch decision unit.
- BrTargetE  in  32  resolved branch target.
- PredTakenE  in  1  PredTakenF, piped to EX.
- PredTargetE  in  32  PredTargetF, piped to EX.
- StallE  in  1  EX stage held this cycle.
- MispredictE  out  1  flush request for IF and ID.
- CorrectPCE  out  32  PC to refetch when MispredictE=1.
- BranchCnt  out  32  count of resolved branches.
- MissCnt  out  32  count of mispredictions.

Function
REQ-004 Each entry SHALL hold: valid bit, tag, 32-bit target, and a 2-bit saturating counter.
REQ-005 Index SHALL be PC[IW+1:2] with IW = log2(ENTRIES); tag SHALL be PC[31:IW+2].
REQ-006 Lookup SHALL be combinational, zero latency: hit = valid and tag match.
- PredTakenF = hit and counter[1].
- PredTargetF = stored target if PredTakenF, else PCF+4.
REQ-007 A qualified update SHALL occur when BranchTypeE != NOBRANCH, StallE=0 and CPU_RST=0.
REQ-008 Qualified update on a table hit at PCE:
- Counter increments if BranchE=1, decrements if BranchE=0.
- Counter saturates at 3 and at 0.
- Target is overwritten with BrTargetE when BranchE=1.
REQ-009 Qualified update on a table miss:
- BranchE=1: allocate the entry (overwrite any occupant) with valid=1, new tag, target=BrTargetE, counter=2 (weakly taken).
- BranchE=0: the table SHALL NOT change.
REQ-010 If the same index is looked up and written in one cycle, lookup SHALL return the pre-write contents; the new contents are visible from the next cycle.
REQ-011 MispredictE SHALL be combinational, and 1 only when StallE=0, CPU_RST=0 and one of:
- qualified branch with BranchE != PredTakenE;
- qualified branch with BranchE=PredTakenE=1 and PredTargetE != BrTargetE;
- BranchTypeE = NOBRANCH with PredTakenE=1.
REQ-012 CorrectPCE SHALL be BrTargetE when the instruction is a branch and BranchE=1, else PCE+4; it is valid regardless of MispredictE.
REQ-013 BranchCnt SHALL increment on each qualified update.
REQ-014 MissCnt SHALL increment on each cycle MispredictE=1.
REQ-015 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-016 While StallE=1, no table or counter state SHALL change and MispredictE SHALL be 0.

Reset
REQ-017 On CPU_RST=1 at a rising edge:
- all valid bits clear;
- all 2-bit counters go to 1 (weakly not-taken);
- BranchCnt and MissCnt go to 0.
REQ-018 Tags and targets need no reset.
REQ-019 After reset, PredTakenF=0 and PredTargetF=PCF+4 until an allocation occurs.
REQ-020 Reset asserted mid-update SHALL win: no allocation or count occurs that cycle.

Structure
REQ-021 The BranchType codes (BEQ, BNE, BLT, BLTU, BGE, BGEU, NOBRANCH) SHALL come from the shared parameters header, not be redefined locally.
REQ-022 The 2-bit saturating counter SHALL be a sub-module named sat_counter2 (inputs inc, dec, rst; output 2-bit state).

Verification
REQ-023 Reset, then PCF=0x00000040 -> PredTakenF=0, PredTargetF=0x00000044.
REQ-024 BEQ at PCE=0x40, BranchE=1, BrTargetE=0x80, PredTakenE=0 -> MispredictE=1, CorrectPCE=0x80; next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x80; BranchCnt=1, MissCnt=1.
REQ-025 Same branch resolved not-taken twice (PredTakenE follows PredTakenF) -> counter goes 2->1->0; the first resolution mispredicts, the second does not; PredTakenF=0 afterwards.
REQ-026 ENTRIES=16; taken branches at 0x40 and 0x80 (same index, different tags) -> second allocation evicts first; lookup of 0x40 misses.
REQ-027 StallE=1 with qualified-looking branch and PredTakenE mismatch -> MispredictE=0, table and counters unchanged; on release the update occurs exactly once.
REQ-028 Drive BranchCnt to 0xFFFFFFFF via force, then one qualified branch -> BranchCnt=0.
